fft_bf_stage_param: RTL and testbench
=====================================

// Module: fft_bf_stage_param
// PURPOSE
// Generic radix-2 DIF butterfly stage for the parallel FFT datapath: LANES samples/cycle, pairs lane i with i+SPAN,
// twiddle-multiplies the difference leg and rounds/saturates to O_WIDTH. One instance per FFT stage, chained by valid;
// replaces the fixed 16-lane hard-wired stage sub-blocks. Adds inverse mode, runtime scaling, overflow flagging, frame tracking.
// PARAMETERS
// FFT_N     512  total points per frame (power of 2)
// LANES     16   samples per valid beat (power of 2, <= FFT_N)
// SPAN      8    butterfly distance in global index (power of 2, 1..LANES/2)
// I_WIDTH   12   signed input width
// O_WIDTH   13   signed output width
// TW_W      10   signed twiddle width, 1.0 = 2^(TW_W-2)
// PORTS
// clk        in   1                   clock, rising edge
// rst        in   1                   asynchronous active-high reset
// in_valid   in   1                   din_* carry beat valid this cycle
// inverse    in   1                   1 = IFFT (conjugate twiddles); sampled per beat with in_valid
// scale_en   in   1                   1 = divide result by 2 (round-half-up); sampled per beat
// ovf_clr    in   1                   clears ovf_sticky
// din_re     in   [LANES][I_WIDTH]    real parts, lane 0 = lowest global index
// din_im     in   [LANES][I_WIDTH]    imaginary parts
// dout_re    out  [LANES][O_WIDTH]    real results
// dout_im    out  [LANES][O_WIDTH]    imaginary results
// out_valid  out  1                   dout_* valid
// out_blk    out  log2(FFT_N/LANES)   beat index within frame of current output
// frame_done out  1                   pulses with last beat of a frame on output
// ovf_sticky out  1                   set on any saturation event
// BEHAVIOUR
// - Reset: all pipeline regs, dout_*, out_valid, out_blk, frame_done, ovf_sticky = 0; beat counter = 0. Async assert, sync release.
// - Beat counter blk: increments on each in_valid, wraps FFT_N/LANES-1 -> 0. Invalid cycles hold it. No backpressure.
// - Global index g = blk*LANES + i. Lane i is upper iff (g/SPAN) even; partner p = i+SPAN.
// - Pipeline, fixed latency 3 cycles in_valid -> out_valid; every stage advances each cycle (bubbles propagate).
//   S1: u = a+b, d = a-b at I_WIDTH+1 bits, no loss.
//   S2: upper leg passes u. Lower leg: d * W, k = g mod SPAN, W = exp(-j*pi*k/SPAN) (conj. if inverse).
//       k=0 bypasses multiplier (exact). Complex product full width, then >>(TW_W-2) with round-half-up.
//   S3: if scale_en: >>1 round-half-up. Saturate to O_WIDTH (to +/-(2^(O_WIDTH-1)-1) / -2^(O_WIDTH-1)).
// - Upper lane i gets u, lane p gets twiddled d (in-place ordering, no reorder in this block).
// - inverse/scale_en/blk/g travel with data through pipeline; mid-stream changes affect only the later beats.
// - ovf_sticky: set when any lane saturates on a valid output beat; ovf_clr same cycle as a new overflow -> stays 1 (set wins).
// - frame_done = out_valid && out_blk == FFT_N/LANES-1.
// - Reset mid-frame: in-flight beats discarded, counter restarts at 0; next beat is treated as frame start.
// - dout_* hold last value when out_valid=0.
// STRUCTURE
// - Package fft_pkg: cplx_t typedef parameter helpers, round_shift/saturate functions, twiddle ROM generator
//   function tw_rom(k, SPAN, TW_W) (elaboration-time cos/sin, rounded to nearest).
// - Sub-module fft_cmul_rnd: one pipelined complex multiply + round, instanced per lower lane (LANES/2).
// - Elaboration asserts: SPAN <= LANES/2, O_WIDTH >= 2, power-of-2 params.
// TESTING
// 1. Reset: rst=1 with in_valid toggling -> all outputs 0; release -> first beat out_valid exactly 3 cycles after in_valid.
// 2. SPAN=8, LANES=16, a=100, b=20 (all lanes, im=0), scale_en=0 -> upper dout_re=120, lower k=0 lane -> 80, k=4 -> re 0, im -80.
// 3. inverse=1 same stimulus -> lower k=4 lane im=+80; other values identical to scenario 2.
// 4. a=b=2047, O_WIDTH=12, scale_en=0 -> upper saturates to 2047, ovf_sticky=1; ovf_clr pulse -> 0 next cycle.
// 5. 32 back-to-back beats with random gaps, FFT_N=512 -> out_blk 0..31 then wraps; frame_done once per 32 beats.
// 6. Random frames vs. float DIF model -> error <= 1 LSB per lane with scale_en 0 and 1; rst mid-frame -> counter restart.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared rounding/saturation helpers and the elaboration-time twiddle generator
package fft_pkg;
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;
  localparam int QB = 28;
  localparam longint PI_Q = 64'sd843314857;
  function automatic longint round_shift(longint x, int s);
    return (x + (longint'(1) << (s - 1))) >>> s;
  endfunction
  function automatic longint saturate(longint x, int w);
    longint mx;
    mx = (longint'(1) << (w - 1)) - 1;
    return x > mx ? mx : x < -mx - 1 ? -mx - 1 : x;
  endfunction
  function automatic logic is_sat(longint x, int w);
    return saturate(x, w) != x;
  endfunction
  // exp(-j*pi*k/span) scaled to 2^(tw_w-2); Taylor series in Q28 keeps this integer-only
  function automatic cplx_t tw_rom(int k, int span, int tw_w);
    longint x, x2, s, c, ts, tc, one;
    cplx_t w;
    one = longint'(1) << QB;
    x = PI_Q * longint'(k) / longint'(span);
    x2 = (x * x) >>> QB;
    s = x;
    c = one;
    ts = x;
    tc = one;
    for (int n = 1; n <= 12; n++) begin
      ts = -((ts * x2) >>> QB) / longint'(2 * n * (2 * n + 1));
      tc = -((tc * x2) >>> QB) / longint'((2 * n - 1) * (2 * n));
      s += ts;
      c += tc;
    end
    w.re = 32'(((c << (tw_w - 2)) + (one >>> 1)) >>> QB);
    w.im = 32'(-(((s << (tw_w - 2)) + (one >>> 1)) >>> QB));
    return w;
  endfunction
endpackage

// File: rtl/fft_cmul_rnd.sv
// fft_cmul_rnd: registered complex multiply by a twiddle, rounded back to the data scale
module fft_cmul_rnd
  import fft_pkg::*;
#(
  parameter int DW = 13,
  parameter int TW_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byp_i,
  input  logic signed [DW-1:0] d_re_i,
  input  logic signed [DW-1:0] d_im_i,
  input  logic signed [TW_W-1:0] w_re_i,
  input  logic signed [TW_W-1:0] w_im_i,
  output logic signed [DW:0]   q_re_o,
  output logic signed [DW:0]   q_im_o
);
  localparam int PW = DW + TW_W + 1;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [DW:0] q_re_d, q_im_d;
  always_comb begin
    p_re = PW'(d_re_i) * PW'(w_re_i) - PW'(d_im_i) * PW'(w_im_i);
    p_im = PW'(d_re_i) * PW'(w_im_i) + PW'(d_im_i) * PW'(w_re_i);
    q_re_d = byp_i ? (DW + 1)'(d_re_i) : (DW + 1)'(round_shift(longint'(p_re), TW_W - 2));
    q_im_d = byp_i ? (DW + 1)'(d_im_i) : (DW + 1)'(round_shift(longint'(p_im), TW_W - 2));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_re_o <= '0;
      q_im_o <= '0;
    end else begin
      q_re_o <= q_re_d;
      q_im_o <= q_im_d;
    end
endmodule

// File: rtl/fft_bf_stage_param.sv
// fft_bf_stage_param: radix-2 DIF butterfly stage, LANES samples per beat, fixed 3-cycle latency
module fft_bf_stage_param
  import fft_pkg::*;
#(
  parameter int FFT_N = 512,
  parameter int LANES = 16,
  parameter int SPAN = 8,
  parameter int I_WIDTH = 12,
  parameter int O_WIDTH = 13,
  parameter int TW_W = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              inverse,
  input  logic                              scale_en,
  input  logic                              ovf_clr,
  input  logic [LANES-1:0][I_WIDTH-1:0]     din_re,
  input  logic [LANES-1:0][I_WIDTH-1:0]     din_im,
  output logic [LANES-1:0][O_WIDTH-1:0]     dout_re,
  output logic [LANES-1:0][O_WIDTH-1:0]     dout_im,
  output logic                              out_valid,
  output logic [$clog2(FFT_N/LANES)-1:0]    out_blk,
  output logic                              frame_done,
  output logic                              ovf_sticky
);
  localparam int BW = $clog2(FFT_N / LANES);
  localparam int UW = I_WIDTH + 1;
  localparam int MW = I_WIDTH + 2;
  if (SPAN < 1 || SPAN > LANES / 2) begin : g_e0
    $error("SPAN must be within 1..LANES/2");
  end
  if (O_WIDTH < 2 || TW_W < 3) begin : g_e1
    $error("O_WIDTH must be >= 2 and TW_W >= 3");
  end
  if ((FFT_N & (FFT_N - 1)) != 0 || (LANES & (LANES - 1)) != 0 || (SPAN & (SPAN - 1)) != 0 || FFT_N <= LANES) begin : g_e2
    $error("FFT_N, LANES, SPAN must be powers of 2 with FFT_N > LANES");
  end
  logic [BW-1:0] blk_q, b1_q, b2_q;
  logic v1_q, v2_q, inv1_q, s1_q, s2_q, sat;
  logic signed [MW-1:0] m_re [LANES];
  logic signed [MW-1:0] m_im [LANES];
  logic [LANES-1:0][O_WIDTH-1:0] y_re, y_im;
  // LANES is a multiple of 2*SPAN, so pairing and twiddle index depend only on the lane
  for (genvar j = 0; j < LANES / 2; j++) begin : g_bf
    localparam int U = (j / SPAN) * 2 * SPAN + j % SPAN;
    localparam int P = U + SPAN;
    localparam cplx_t W = tw_rom(j % SPAN, SPAN, TW_W);
    logic signed [UW-1:0] u_re_q, u_im_q, d_re_q, d_im_q;
    logic signed [MW-1:0] h_re_q, h_im_q;
    logic signed [TW_W-1:0] w_re, w_im;
    assign w_re = TW_W'(W.re);
    assign w_im = inv1_q ? -TW_W'(W.im) : TW_W'(W.im);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        u_re_q <= '0;
        u_im_q <= '0;
        d_re_q <= '0;
        d_im_q <= '0;
        h_re_q <= '0;
        h_im_q <= '0;
      end else begin
        u_re_q <= UW'($signed(din_re[U])) + UW'($signed(din_re[P]));
        u_im_q <= UW'($signed(din_im[U])) + UW'($signed(din_im[P]));
        d_re_q <= UW'($signed(din_re[U])) - UW'($signed(din_re[P]));
        d_im_q <= UW'($signed(din_im[U])) - UW'($signed(din_im[P]));
        h_re_q <= MW'(u_re_q);
        h_im_q <= MW'(u_im_q);
      end
    fft_cmul_rnd #(.DW(UW), .TW_W(TW_W)) u_mul (
      .clk(clk), .rst(rst), .byp_i(j % SPAN == 0),
      .d_re_i(d_re_q), .d_im_i(d_im_q), .w_re_i(w_re), .w_im_i(w_im),
      .q_re_o(m_re[P]), .q_im_o(m_im[P])
    );
    assign m_re[U] = h_re_q;
    assign m_im[U] = h_im_q;
  end
  always_comb begin
    longint r, q;
    r = '0;
    q = '0;
    sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      r = s2_q ? round_shift(longint'(m_re[i]), 1) : longint'(m_re[i]);
      q = s2_q ? round_shift(longint'(m_im[i]), 1) : longint'(m_im[i]);
      y_re[i] = O_WIDTH'(saturate(r, O_WIDTH));
      y_im[i] = O_WIDTH'(saturate(q, O_WIDTH));
      sat = sat | is_sat(r, O_WIDTH) | is_sat(q, O_WIDTH);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      blk_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      inv1_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      out_valid <= 1'b0;
      out_blk <= '0;
      frame_done <= 1'b0;
      ovf_sticky <= 1'b0;
      dout_re <= '0;
      dout_im <= '0;
    end else begin
      blk_q <= in_valid ? blk_q + 1'b1 : blk_q;
      b1_q <= blk_q;
      b2_q <= b1_q;
      v1_q <= in_valid;
      v2_q <= v1_q;
      inv1_q <= inverse;
      s1_q <= scale_en;
      s2_q <= s1_q;
      out_valid <= v2_q;
      frame_done <= v2_q && (&b2_q);
      ovf_sticky <= (ovf_sticky && !ovf_clr) || (v2_q && sat);
      if (v2_q) begin
        dout_re <= y_re;
        dout_im <= y_im;
        out_blk <= b2_q;
      end
    end
endmodule

// File: tb/tb_fft_bf_stage_param.sv
// tb_fft_bf_stage_param: directed vectors, pipeline/framing sequences and a float DIF model for the butterfly stage
module tb_fft_bf_stage_param;
  localparam int L = 16, S = 8, IW = 12, OW = 12, NB = 32;
  localparam real PI = 3.14159265358979;
  logic clk = 1'b0;
  logic rst, in_valid, inverse, scale_en, ovf_clr;
  logic [L-1:0][IW-1:0] din_re, din_im;
  logic [L-1:0][OW-1:0] dout_re, dout_im;
  logic out_valid, frame_done, ovf_sticky;
  logic [4:0] out_blk;
  int checks = 0, failures = 0;
  int sent, seen, fd, eb, wi, ri;
  real er [64][L];
  real ei [64][L];

  typedef struct {
    int ar, ai, br, bi;
    bit inv, scl, clr;
    int e0r, e0i, e8r, e8i, e10r, e10i, e12r, e12i;
    bit eovf;
  } vec_t;
  vec_t vt [8];

  fft_bf_stage_param #(.FFT_N(512), .LANES(L), .SPAN(S), .I_WIDTH(IW), .O_WIDTH(OW), .TW_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse), .scale_en(scale_en), .ovf_clr(ovf_clr),
    .din_re(din_re), .din_im(din_im), .dout_re(dout_re), .dout_im(dout_im), .out_valid(out_valid),
    .out_blk(out_blk), .frame_done(frame_done), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chkr(string n, int act, real exp);
    checks++;
    if ($itor(act) > exp + 1.0 || $itor(act) < exp - 1.0) begin
      failures++;
      $display("FAIL %s: got %0d expected %0.2f within 1 LSB", n, act, exp);
    end
  endtask

  task automatic drive(int ar, int ai, int br, int bi);
    for (int i = 0; i < L; i++) begin
      din_re[i] = IW'((i / S) % 2 == 0 ? ar : br);
      din_im[i] = IW'((i / S) % 2 == 0 ? ai : bi);
    end
  endtask

  function automatic real clip(real x);
    return x > 2047.0 ? 2047.0 : x < -2048.0 ? -2048.0 : x;
  endfunction

  // floating-point DIF reference built from the inputs currently on the pins
  task automatic model(int idx);
    for (int j = 0; j < L / 2; j++) begin
      int u, p, k;
      real ar, ai, br, bi, wr, wq, dr, di, lr, li, sc;
      u = (j / S) * 2 * S + j % S;
      p = u + S;
      k = j % S;
      ar = $itor(sx(din_re[u]));
      ai = $itor(sx(din_im[u]));
      br = $itor(sx(din_re[p]));
      bi = $itor(sx(din_im[p]));
      wr = $floor(256.0 * $cos(PI * k / S) + 0.5);
      wq = $floor(-256.0 * $sin(PI * k / S) + 0.5);
      if (inverse) wq = -wq;
      dr = ar - br;
      di = ai - bi;
      lr = (k == 0) ? dr : (dr * wr - di * wq) / 256.0;
      li = (k == 0) ? di : (dr * wq + di * wr) / 256.0;
      sc = scale_en ? 0.5 : 1.0;
      er[idx][u] = clip((ar + br) * sc);
      ei[idx][u] = clip((ai + bi) * sc);
      er[idx][p] = clip(lr * sc);
      ei[idx][p] = clip(li * sc);
    end
  endtask

  initial begin
    vt[0] = '{100, 0, 20, 0, 0, 0, 0, 120, 0, 80, 0, 57, -57, 0, -80, 0};
    vt[1] = '{100, 0, 20, 0, 1, 0, 0, 120, 0, 80, 0, 57, 57, 0, 80, 0};
    vt[2] = '{100, 0, 21, 0, 0, 1, 0, 61, 0, 40, 0, 28, -28, 0, -39, 0};
    vt[3] = '{2047, 2047, 2047, 2047, 0, 0, 0, 2047, 2047, 0, 0, 0, 0, 0, 0, 1};
    vt[4] = '{2047, 2047, 2047, 2047, 0, 1, 1, 2047, 2047, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{-2048, -2048, -2048, -2048, 0, 0, 0, -2048, -2048, 0, 0, 0, 0, 0, 0, 1};
    vt[6] = '{-2048, 0, 2047, 0, 0, 0, 1, -1, 0, -2048, 0, -2048, 2047, 0, 2047, 1};
    vt[7] = '{0, 50, 0, -30, 0, 0, 1, 0, 20, 0, 80, 57, 57, 80, 0, 0};

    rst = 1'b1; in_valid = 1'b0; inverse = 1'b0; scale_en = 1'b0; ovf_clr = 1'b0;
    drive(100, 0, 20, 0);
    repeat (4) begin
      in_valid = ~in_valid;
      tick;
    end
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", int'(|{dout_re, dout_im}), 0);
    chk("rst_blk", out_blk, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf_sticky, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick;

    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("lat_c1", out_valid, 0);
    tick;
    chk("lat_c2", out_valid, 0);
    tick;
    chk("lat_c3", out_valid, 1);
    chk("lat_blk", out_blk, 0);
    chk("lat_re0", sx(dout_re[0]), 120);
    tick;
    chk("lat_c4", out_valid, 0);
    chk("hold_re0", sx(dout_re[0]), 120);

    foreach (vt[n]) begin
      drive(vt[n].ar, vt[n].ai, vt[n].br, vt[n].bi);
      in_valid = 1'b1; inverse = vt[n].inv; scale_en = vt[n].scl; ovf_clr = vt[n].clr;
      tick;
      in_valid = 1'b0; inverse = 1'b0; scale_en = 1'b0; ovf_clr = 1'b0;
      tick;
      tick;
      chk($sformatf("v%0d_valid", n), out_valid, 1);
      chk($sformatf("v%0d_l0_re", n), sx(dout_re[0]), vt[n].e0r);
      chk($sformatf("v%0d_l0_im", n), sx(dout_im[0]), vt[n].e0i);
      chk($sformatf("v%0d_l8_re", n), sx(dout_re[8]), vt[n].e8r);
      chk($sformatf("v%0d_l8_im", n), sx(dout_im[8]), vt[n].e8i);
      chk($sformatf("v%0d_l10_re", n), sx(dout_re[10]), vt[n].e10r);
      chk($sformatf("v%0d_l10_im", n), sx(dout_im[10]), vt[n].e10i);
      chk($sformatf("v%0d_l12_re", n), sx(dout_re[12]), vt[n].e12r);
      chk($sformatf("v%0d_l12_im", n), sx(dout_im[12]), vt[n].e12i);
      chk($sformatf("v%0d_ovf", n), ovf_sticky, int'(vt[n].eovf));
    end

    drive(2047, 2047, 2047, 2047);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf_sticky, 0);

    in_valid = 1'b1;
    tick;
    tick;
    tick;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_ovf", ovf_sticky, 1);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", out_valid, 0);
    chk("mid_async_ovf", ovf_sticky, 0);
    chk("mid_async_re0", sx(dout_re[0]), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick;
    chk("mid_flush1", out_valid, 0);
    tick;
    chk("mid_flush2", out_valid, 0);
    drive(100, 0, 20, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk("mid_restart_valid", out_valid, 1);
    chk("mid_restart_blk", out_blk, 0);
    chk("mid_restart_re0", sx(dout_re[0]), 120);

    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick;
    sent = 0; seen = 0; fd = 0; eb = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid = (sent < 40) && ($urandom_range(3) != 0);
      if (in_valid) sent++;
      tick;
      if (out_valid) begin
        chk($sformatf("blk_b%0d", seen), out_blk, eb);
        chk($sformatf("frame_done_b%0d", seen), frame_done, int'(eb == NB - 1));
        fd += int'(frame_done);
        eb = (eb + 1) % NB;
        seen++;
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
    end
    in_valid = 1'b0;
    chk("stream_beats", seen, 40);
    chk("frame_done_count", fd, 1);

    wi = 0; ri = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (wi < 24) && ($urandom_range(4) != 0);
      if (in_valid) begin
        int amp;
        amp = $urandom_range(1) != 0 ? 4095 : 255;
        for (int i = 0; i < L; i++) begin
          din_re[i] = IW'(int'($urandom_range(amp)) - (amp + 1) / 2);
          din_im[i] = IW'(int'($urandom_range(amp)) - (amp + 1) / 2);
        end
        inverse = 1'($urandom_range(1));
        scale_en = 1'($urandom_range(1));
        model(wi);
        wi++;
      end
      tick;
      if (out_valid && ri < 64) begin
        for (int i = 0; i < L; i++) begin
          chkr($sformatf("model_b%0d_l%0d_re", ri, i), sx(dout_re[i]), er[ri][i]);
          chkr($sformatf("model_b%0d_l%0d_im", ri, i), sx(dout_im[i]), ei[ri][i]);
        end
        ri++;
      end
    end
    in_valid = 1'b0;
    chk("model_beats", ri, wi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
